// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bundle: MEM-stage pipeline port, secondary (loader/debug DMA) port
// and the single data-memory port, as seen from the arbiter (slave) and its environment (master).
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stall;

  logic              s_valid;
  logic              s_ready;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_done;
  logic [DATA_W-1:0] s_rdata;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  s_valid, s_we, s_addr, s_wdata,
    input  mem_rdata,
    output p_rdata, p_stall,
    output s_ready, s_done, s_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output s_valid, s_we, s_addr, s_wdata,
    output mem_rdata,
    input  p_rdata, p_stall,
    input  s_ready, s_done, s_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the MEM-stage pipeline port (priority, stalled when not
// served) and a valid/ready secondary port, with optional synchronous read latency.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STARVE_W = 4;
  localparam logic [LAT_W-1:0]    LAT_INIT = LAT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_P, OWN_S} owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  req_t                req_q, req_d;
  logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;

  logic              grant_p, grant_s;
  logic              p_fin, s_fin;
  logic              mem_re_c, mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // State, latched request, starvation counter and read-data holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_P;
      lat_q     <= '0;
      starve_q  <= '0;
      req_q     <= '0;
      p_rdata_q <= '0;
      s_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      req_q     <= req_d;
      p_rdata_q <= p_rdata_d;
      s_rdata_q <= s_rdata_d;
    end
  end

  // Grant, memory sequencing and completion decode
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    req_d       = req_q;
    p_rdata_d   = p_rdata_q;
    s_rdata_d   = s_rdata_q;
    grant_p     = 1'b0;
    grant_s     = 1'b0;
    p_fin       = 1'b0;
    s_fin       = 1'b0;
    mem_re_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is asserted so every output reads as idle
        if (rst_n && bus.s_valid && (!bus.p_req || (starve_q == STARVE_LIM))) begin
          grant_s = 1'b1;
        end else if (rst_n && bus.p_req) begin
          grant_p = 1'b1;
        end

        if (grant_s) begin
          req_d.we    = bus.s_we;
          req_d.addr  = bus.s_addr;
          req_d.wdata = bus.s_wdata;
          owner_d     = OWN_S;
        end else if (grant_p) begin
          req_d.we    = bus.p_we;
          req_d.addr  = bus.p_addr;
          req_d.wdata = bus.p_wdata;
          owner_d     = OWN_P;
        end

        if (grant_s || grant_p) begin
          mem_re_c    = !req_d.we;
          mem_we_c    = req_d.we;
          mem_addr_c  = req_d.addr;
          mem_wdata_c = req_d.wdata;
          if (req_d.we || (MEM_LAT == 0)) begin
            p_fin = grant_p;
            s_fin = grant_s;
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end

      RD_WAIT: begin
        mem_re_c    = !req_q.we;
        mem_addr_c  = req_q.addr;
        mem_wdata_c = req_q.wdata;
        if (lat_q == '0) begin
          state_d = IDLE;
          p_fin   = (owner_q == OWN_P);
          s_fin   = (owner_q == OWN_S);
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (p_fin && !req_d.we) p_rdata_d = bus.mem_rdata;
    if (s_fin && !req_d.we) s_rdata_d = bus.mem_rdata;

    if (!bus.s_valid || grant_s) begin
      starve_d = '0;
    end else if (grant_p && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign bus.mem_re    = mem_re_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  // Read data bypasses the holding register in its completion cycle
  assign bus.p_rdata = (p_fin && !req_d.we) ? bus.mem_rdata : p_rdata_q;
  assign bus.s_rdata = (s_fin && !req_d.we) ? bus.mem_rdata : s_rdata_q;
  assign bus.p_stall = rst_n && bus.p_req && !p_fin;
  assign bus.s_ready = grant_s;
  assign bus.s_done  = s_fin;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: four lanes with MEM_LAT 0..3 share clock/reset, each lane
// has its own memory model that returns valid data exactly MEM_LAT cycles after read issue.
module tb_dmem_arbiter;

  localparam int NL = 4;
  localparam logic [31:0] D   = 32'hDEADBEEF;
  localparam logic [31:0] Q   = 32'h12345678;
  localparam logic [31:0] C   = 32'hCAFEF00D;
  localparam logic [31:0] A30 = 32'hA0000030;
  localparam logic [31:0] A24 = 32'hA0000024;
  localparam logic [31:0] WA  = 32'hA5A5A5A5;
  localparam logic [31:0] BAD = 32'hBAD0BAD0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NL-1:0] p_req_a, p_we_a, s_valid_a, s_we_a;
  logic [31:0]   p_addr_a [NL];
  logic [31:0]   p_wdata_a[NL];
  logic [31:0]   s_addr_a [NL];
  logic [31:0]   s_wdata_a[NL];

  logic [NL-1:0] p_stall_a, s_ready_a, s_done_a, mem_re_a, mem_we_a;
  logic [31:0]   p_rdata_a  [NL];
  logic [31:0]   s_rdata_a  [NL];
  logic [31:0]   mem_addr_a [NL];
  logic [31:0]   mem_wdata_a[NL];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10:  return D;
      32'h20:  return Q;
      32'h80:  return C;
      default: return 32'hA000_0000 | a;
    endcase
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    logic [2:0] age;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Memory model: data is only valid on the MEM_LAT-th cycle of a held read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) age <= 3'd0;
      else        age <= (bus.mem_re && (age < 3'(g))) ? age + 3'd1 : 3'd0;
    end
    assign bus.mem_rdata = (bus.mem_re && (age == 3'(g))) ? mem_val(bus.mem_addr) : BAD;

    assign bus.p_req   = p_req_a[g];
    assign bus.p_we    = p_we_a[g];
    assign bus.p_addr  = p_addr_a[g];
    assign bus.p_wdata = p_wdata_a[g];
    assign bus.s_valid = s_valid_a[g];
    assign bus.s_we    = s_we_a[g];
    assign bus.s_addr  = s_addr_a[g];
    assign bus.s_wdata = s_wdata_a[g];

    assign p_stall_a[g]   = bus.p_stall;
    assign s_ready_a[g]   = bus.s_ready;
    assign s_done_a[g]    = bus.s_done;
    assign mem_re_a[g]    = bus.mem_re;
    assign mem_we_a[g]    = bus.mem_we;
    assign p_rdata_a[g]   = bus.p_rdata;
    assign s_rdata_a[g]   = bus.s_rdata;
    assign mem_addr_a[g]  = bus.mem_addr;
    assign mem_wdata_a[g] = bus.mem_wdata;
  end

  typedef struct {
    int          lane;
    logic        p_req, p_we;
    logic [31:0] p_addr, p_wdata;
    logic        s_valid, s_we;
    logic [31:0] s_addr, s_wdata;
    logic        e_stall;
    logic [31:0] e_prd;
    logic        e_srdy, e_sdone;
    logic [31:0] e_srd;
    logic        e_re, e_we;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input int lane,
      input logic [31:0] preq, pwe, paddr, pwd, sval, swe, saddr, swd,
      input logic [31:0] stall, prd, srdy, sdone, srd, re, we, addr, wd);
    vec_t r;
    r.lane = lane;
    r.p_req = preq[0]; r.p_we = pwe[0]; r.p_addr = paddr; r.p_wdata = pwd;
    r.s_valid = sval[0]; r.s_we = swe[0]; r.s_addr = saddr; r.s_wdata = swd;
    r.e_stall = stall[0]; r.e_prd = prd; r.e_srdy = srdy[0]; r.e_sdone = sdone[0];
    r.e_srd = srd; r.e_re = re[0]; r.e_we = we[0]; r.e_addr = addr; r.e_wd = wd;
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int l = 0; l < NL; l++) begin
      p_req_a[l] = 1'b0; p_we_a[l] = 1'b0; p_addr_a[l] = '0; p_wdata_a[l] = '0;
      s_valid_a[l] = 1'b0; s_we_a[l] = 1'b0; s_addr_a[l] = '0; s_wdata_a[l] = '0;
    end
  endtask

  task automatic apply(input vec_t r);
    p_req_a[r.lane] = r.p_req;     p_we_a[r.lane] = r.p_we;
    p_addr_a[r.lane] = r.p_addr;   p_wdata_a[r.lane] = r.p_wdata;
    s_valid_a[r.lane] = r.s_valid; s_we_a[r.lane] = r.s_we;
    s_addr_a[r.lane] = r.s_addr;   s_wdata_a[r.lane] = r.s_wdata;
  endtask

  task automatic check_vec(input int i, input vec_t r);
    int l;
    string t;
    l = r.lane;
    t = $sformatf("v%0d lane%0d", i, l);
    cmp({t, " p_stall"},  32'(p_stall_a[l]), 32'(r.e_stall));
    cmp({t, " p_rdata"},  p_rdata_a[l],      r.e_prd);
    cmp({t, " s_ready"},  32'(s_ready_a[l]), 32'(r.e_srdy));
    cmp({t, " s_done"},   32'(s_done_a[l]),  32'(r.e_sdone));
    cmp({t, " s_rdata"},  s_rdata_a[l],      r.e_srd);
    cmp({t, " mem_re"},   32'(mem_re_a[l]),  32'(r.e_re));
    cmp({t, " mem_we"},   32'(mem_we_a[l]),  32'(r.e_we));
    cmp({t, " mem_addr"}, mem_addr_a[l],     r.e_addr);
    if (r.e_we) cmp({t, " mem_wdata"}, mem_wdata_a[l], r.e_wd);
  endtask

  task automatic check_idle(input string t, input int l, input logic [31:0] prd, input logic [31:0] srd);
    cmp({t, " p_stall"}, 32'(p_stall_a[l]), 32'd0);
    cmp({t, " s_ready"}, 32'(s_ready_a[l]), 32'd0);
    cmp({t, " s_done"},  32'(s_done_a[l]),  32'd0);
    cmp({t, " mem_re"},  32'(mem_re_a[l]),  32'd0);
    cmp({t, " mem_we"},  32'(mem_we_a[l]),  32'd0);
    cmp({t, " mem_addr"}, mem_addr_a[l],    32'd0);
    cmp({t, " p_rdata"}, p_rdata_a[l],      prd);
    cmp({t, " s_rdata"}, s_rdata_a[l],      srd);
  endtask

  initial begin
    logic [31:0] exp_p[NL];
    logic [31:0] exp_s[NL];

    // Lane 0, MEM_LAT=0: back-to-back zero-stall reads, a write, an S read, idle
    for (int k = 0; k < 4; k++)
      vq.push_back(v(0, 1,0,'h10,0,  0,0,0,0,        0,D,0,0,0,    1,0,'h10,0));
    vq.push_back(v(0, 1,1,'h14,'h11223344, 0,0,0,0, 0,D,0,0,0,    0,1,'h14,'h11223344));
    vq.push_back(v(0, 0,0,0,0,     1,0,'h30,0,     0,D,1,1,A30,  1,0,'h30,0));
    vq.push_back(v(0, 0,0,0,0,     0,0,0,0,        0,D,0,0,A30,  0,0,0,0));
    // Lane 1, MEM_LAT=1: four P grants then S forced in; counter restarts after S grant
    for (int k = 0; k < 4; k++) begin
      vq.push_back(v(1, 1,0,'h20,0, 1,1,'h40,WA,   1,(k == 0) ? 32'd0 : Q,0,0,0, 1,0,'h20,0));
      vq.push_back(v(1, 1,0,'h20,0, 1,1,'h40,WA,   0,Q,0,0,0,    1,0,'h20,0));
    end
    vq.push_back(v(1, 1,0,'h20,0,  1,1,'h40,WA,    1,Q,1,1,0,    0,1,'h40,WA));
    vq.push_back(v(1, 1,0,'h20,0,  1,1,'h44,5,     1,Q,0,0,0,    1,0,'h20,0));
    vq.push_back(v(1, 1,0,'h20,0,  1,1,'h44,5,     0,Q,0,0,0,    1,0,'h20,0));
    vq.push_back(v(1, 0,0,0,0,     1,1,'h44,5,     0,Q,1,1,0,    0,1,'h44,5));
    vq.push_back(v(1, 0,0,0,0,     0,0,0,0,        0,Q,0,0,0,    0,0,0,0));
    // Lane 2, MEM_LAT=2: single P read with two stall cycles
    vq.push_back(v(2, 1,0,'h20,0,  0,0,0,0,        1,0,0,0,0,    1,0,'h20,0));
    vq.push_back(v(2, 1,0,'h20,0,  0,0,0,0,        1,0,0,0,0,    1,0,'h20,0));
    vq.push_back(v(2, 1,0,'h20,0,  0,0,0,0,        0,Q,0,0,0,    1,0,'h20,0));
    vq.push_back(v(2, 0,0,0,0,     0,0,0,0,        0,Q,0,0,0,    0,0,0,0));
    // Lane 3, MEM_LAT=3: S read holds the memory, P waits and is served afterwards
    vq.push_back(v(3, 0,0,0,0,     1,0,'h80,0,     0,0,1,0,0,    1,0,'h80,0));
    vq.push_back(v(3, 1,0,'h10,0,  0,0,0,0,        1,0,0,0,0,    1,0,'h80,0));
    vq.push_back(v(3, 1,0,'h10,0,  0,0,0,0,        1,0,0,0,0,    1,0,'h80,0));
    vq.push_back(v(3, 1,0,'h10,0,  0,0,0,0,        1,0,0,1,C,    1,0,'h80,0));
    for (int k = 0; k < 3; k++)
      vq.push_back(v(3, 1,0,'h10,0, 0,0,0,0,       1,0,0,0,C,    1,0,'h10,0));
    vq.push_back(v(3, 1,0,'h10,0,  0,0,0,0,        0,D,0,0,C,    1,0,'h10,0));
    vq.push_back(v(3, 0,0,0,0,     0,0,0,0,        0,D,0,0,C,    0,0,0,0));

    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) check_idle($sformatf("reset lane%0d", l), l, 32'd0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      clear_inputs();
      apply(vq[i]);
      #2;
      check_vec(i, vq[i]);
    end

    // Quiet period: nothing granted and read data registers hold
    exp_p[0] = D; exp_s[0] = A30;
    exp_p[1] = Q; exp_s[1] = 32'd0;
    exp_p[2] = Q; exp_s[2] = 32'd0;
    exp_p[3] = D; exp_s[3] = C;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clear_inputs();
      #2;
      for (int l = 0; l < NL; l++) check_idle($sformatf("quiet%0d lane%0d", k, l), l, exp_p[l], exp_s[l]);
    end

    // Asynchronous reset in the middle of a lane-2 read, then a fresh read
    @(negedge clk);
    p_req_a[2] = 1'b1; p_addr_a[2] = 32'h24;
    #2;
    cmp("rst grant p_stall", 32'(p_stall_a[2]), 32'd1);
    cmp("rst grant mem_addr", mem_addr_a[2], 32'h24);
    @(negedge clk);
    #2;
    cmp("rst wait p_stall", 32'(p_stall_a[2]), 32'd1);
    cmp("rst wait mem_re", 32'(mem_re_a[2]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_idle("in-reset lane2", 2, 32'd0, 32'd0);
    cmp("in-reset lane3 s_rdata", s_rdata_a[3], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    cmp("post-rst grant p_stall", 32'(p_stall_a[2]), 32'd1);
    cmp("post-rst grant mem_addr", mem_addr_a[2], 32'h24);
    cmp("post-rst grant p_rdata", p_rdata_a[2], 32'd0);
    @(negedge clk);
    #2;
    cmp("post-rst wait p_stall", 32'(p_stall_a[2]), 32'd1);
    cmp("post-rst wait p_rdata", p_rdata_a[2], 32'd0);
    @(negedge clk);
    #2;
    cmp("post-rst done p_stall", 32'(p_stall_a[2]), 32'd0);
    cmp("post-rst done p_rdata", p_rdata_a[2], A24);
    @(negedge clk);
    clear_inputs();
    #2;
    check_idle("post-rst idle lane2", 2, A24, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
